// File: rtl/fp_add_pkg.sv
// Shared types, constants and helpers for the fp_adder issue/capture sequencer.
package fp_add_pkg;

    localparam int unsigned FP_W       = 32;
    localparam int unsigned FP_EXP_LSB = 23;
    localparam int unsigned FP_EXP_W   = 8;
    localparam int unsigned FP_CNT_W   = 2;

    localparam logic [FP_EXP_W-1:0] FP_EXP_ALL1     = 8'hFF;
    localparam logic [FP_CNT_W-1:0] FP_WAIT_NORMAL  = 2'd3;
    localparam logic [FP_CNT_W-1:0] FP_WAIT_SPECIAL = 2'd1;
    localparam logic [FP_W-1:0]     FP_QNAN         = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_t;

    // Operand pair as stored in the FIFO (64 bits).
    typedef struct packed {
        logic [FP_W-1:0] b;
        logic [FP_W-1:0] a;
    } fp_pair_t;

    // Either operand NaN/Inf: the adder takes its short path.
    function automatic logic fp_is_special(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        return (a[FP_EXP_LSB +: FP_EXP_W] == FP_EXP_ALL1) ||
               (b[FP_EXP_LSB +: FP_EXP_W] == FP_EXP_ALL1);
    endfunction

endpackage

// File: rtl/fp_operand_fifo.sv
// DEPTH-entry synchronous FIFO of operand pairs; head is read from the registered read pointer.
module fp_operand_fifo
    import fp_add_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  fp_pair_t                  wdata_i,
    input  logic                      pop_i,
    output fp_pair_t                  head_c,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_c,
    output logic                      full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fp_pair_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push_c;
    logic            do_pop_c;

    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CW'(DEPTH));
    assign do_push_c = push_i && !full_c;
    assign do_pop_c  = pop_i && !empty_c;
    assign head_c    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Issues buffered operand pairs to fp_adder one at a time and captures its result
// in the predicted FINISH cycle (the adder has no completion strobe).
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_sum,
    output logic            res_error,
    output logic [FP_W-1:0] fpa_a,
    output logic [FP_W-1:0] fpa_b,
    output logic            fpa_data_valid,
    input  logic [FP_W-1:0] fpa_sum,
    input  logic            fpa_error,
    output logic            busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fp_pair_t              wdata_c;
    fp_pair_t              head_c;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty_c;
    logic                  fifo_full_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  slot_free_c;

    seq_state_t            state_q, state_d;
    logic [FP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  special_q, special_d;
    logic [FP_W-1:0]       a_q, a_d, b_q, b_d;
    logic [FP_W-1:0]       sum_q, sum_d;
    logic                  err_q, err_d;
    logic                  rv_q, rv_d;
    logic                  dv_q, dv_d;
    logic                  busy_q, busy_d;

    assign wdata_c.a   = in_a;
    assign wdata_c.b   = in_b;
    assign in_ready    = (fifo_count < CW'(DEPTH));
    assign push_c      = in_valid && !fifo_full_c;
    assign slot_free_c = !rv_q || res_ready;

    fp_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .wdata_i (wdata_c),
        .pop_i   (pop_c),
        .head_c  (head_c),
        .count_o (fifo_count),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_c)
    );

    // Next-state: pop only when the output slot can take the eventual capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        err_d     = err_q;
        rv_d      = rv_q;
        pop_c     = 1'b0;

        if (rv_q && res_ready) rv_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_c && slot_free_c) begin
                    pop_c     = 1'b1;
                    a_d       = head_c.a;
                    b_d       = head_c.b;
                    special_d = fp_is_special(head_c.a, head_c.b);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = special_q ? FP_WAIT_SPECIAL : FP_WAIT_NORMAL;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    sum_d   = fpa_sum;
                    err_d   = fpa_error;
                    rv_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - FP_CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        dv_d   = (state_d == S_ISSUE);
        busy_d = (state_d != S_IDLE);
    end

    // State, operand, counter and output-slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            special_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            rv_q      <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            special_q <= special_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            rv_q      <= rv_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
        end
    end

    assign fpa_a          = a_q;
    assign fpa_b          = b_q;
    assign fpa_data_valid = dv_q;
    assign busy           = busy_q;
    assign res_valid      = rv_q;
    assign res_sum        = sum_q;
    assign res_error      = err_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with a cycle-timed fp_adder model.
module tb_fp_add_sequencer;
    import fp_add_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_sum;
    logic        res_error;
    logic [31:0] fpa_a, fpa_b;
    logic        fpa_data_valid;
    logic [31:0] fpa_sum;
    logic        fpa_error;
    logic        busy;

    typedef struct {
        logic [31:0] sum;
        logic        err;
        int          acc;
        int          lat;
        bit          gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cur_lat = 0;
    bit   cur_gap = 1'b0;
    int   last_acc = 0;
    int   last_first = -1;
    bit   head_seen = 1'b0;

    fp_add_sequencer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_sum        (res_sum),
        .res_error      (res_error),
        .fpa_a          (fpa_a),
        .fpa_b          (fpa_b),
        .fpa_data_valid (fpa_data_valid),
        .fpa_sum        (fpa_sum),
        .fpa_error      (fpa_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed sums for every directed pair: {error, sum}.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return {1'b0, 32'h4040_0000};
            {32'h7F80_0000, 32'h3F80_0000}: return {1'b0, 32'h7F80_0000};
            {32'h7F80_0000, 32'hFF80_0000}: return {1'b1, FP_QNAN};
            {32'h7FC0_0001, 32'h0000_0000}: return {1'b1, FP_QNAN};
            {32'hFF80_0000, 32'h3F80_0000}: return {1'b0, 32'hFF80_0000};
            {32'hBF80_0000, 32'h4000_0000}: return {1'b0, 32'h3F80_0000};
            {32'h4000_0000, 32'h4000_0000}: return {1'b0, 32'h4080_0000};
            {32'h3F80_0000, 32'h3F80_0000}: return {1'b0, 32'h4000_0000};
            {32'h4040_0000, 32'h3F80_0000}: return {1'b0, 32'h4080_0000};
            {32'h40A0_0000, 32'h3F80_0000}: return {1'b0, 32'h40C0_0000};
            {32'h4120_0000, 32'h4000_0000}: return {1'b0, 32'h4140_0000};
            {32'h3F00_0000, 32'h3F00_0000}: return {1'b0, 32'h3F80_0000};
            default:                        return {1'b1, 32'hBAD0_BAD0};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder model: FINISH 4 cycles after the issue cycle (2 for NaN/Inf operands).
    int          rem = -1;
    logic [31:0] lat_a, lat_b;
    bit          moved = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= -1;
        end else begin
            if (rem >= 0) rem <= rem - 1;
            if (fpa_data_valid && rem < 0) begin
                rem   <= ((fpa_a[30:23] == 8'hFF) || (fpa_b[30:23] == 8'hFF)) ? 1 : 3;
                lat_a <= fpa_a;
                lat_b <= fpa_b;
            end
        end
    end

    always_comb begin
        logic [32:0] r;
        r = ref_add(fpa_a, fpa_b);
        if (rem == 0) begin
            fpa_sum   = r[31:0];
            fpa_error = r[32];
        end else begin
            fpa_sum   = 32'hDEAD_BEEF;
            fpa_error = 1'b1;
        end
    end

    // Adder-side protocol checks: single issue pulse, issue timing, operand stability.
    always @(negedge clk) begin
        if (rst) begin
            moved = 1'b0;
        end else begin
            if (fpa_data_valid) begin
                check("issue_overlaps_op", 64'(rem >= 0), 64'(0));
                check("busy_at_issue", 64'(busy), 64'(1));
                if (cur_lat != 0) check("issue_delay", 64'(cyc - last_acc), 64'(2));
            end
            if (rem >= 0 && (fpa_a !== lat_a || fpa_b !== lat_b)) moved = 1'b1;
            if (rem == 0) begin
                check("operands_stable", 64'(moved), 64'(0));
                moved = 1'b0;
            end
        end
    end

    // Stimulus observer: every accepted pair pushes its expected result.
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] r;
        if (!rst && in_valid && in_ready) begin
            r     = ref_add(in_a, in_b);
            e.sum = r[31:0];
            e.err = r[32];
            e.acc = cyc;
            e.lat = cur_lat;
            e.gap = cur_gap;
            sb.push_back(e);
            last_acc = cyc;
        end
    end

    // Result monitor: pops the scoreboard on every res_valid && res_ready transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            head_seen = 1'b0;
        end else if (res_valid) begin
            if (sb.size() == 0) begin
                check("spurious_res_valid", 64'(res_valid), 64'(0));
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if (sb[0].lat != 0) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    if (sb[0].gap && last_first >= 0) check("gap_ge_6", 64'((cyc - last_first) >= 6), 64'(1));
                    last_first = cyc;
                end
                if (res_ready) begin
                    check("res_sum", 64'(res_sum), 64'(sb[0].sum));
                    check("res_error", 64'(res_error), 64'(sb[0].err));
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_a = $urandom;
            in_b = $urandom;
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input int lat, input bit gap);
        int waited;
        waited   = 0;
        cur_lat  = lat;
        cur_gap  = gap;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_sum", 64'(res_sum), 64'(0));
        check("rst_res_error", 64'(res_error), 64'(0));
        check("rst_fpa_a", 64'(fpa_a), 64'(0));
        check("rst_fpa_b", 64'(fpa_b), 64'(0));
        check("rst_fpa_dv", 64'(fpa_data_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Isolated ops: normal 7-cycle and special 5-cycle latency.
        push(32'h3F80_0000, 32'h4000_0000, 7, 1'b0); idle(12);
        push(32'h7F80_0000, 32'h3F80_0000, 5, 1'b0); idle(10);
        push(32'h7F80_0000, 32'hFF80_0000, 5, 1'b0); idle(10);
        push(32'h7FC0_0001, 32'h0000_0000, 5, 1'b0); idle(10);
        push(32'hFF80_0000, 32'h3F80_0000, 5, 1'b0); idle(10);
        push(32'hBF80_0000, 32'h4000_0000, 7, 1'b0); idle(12);

        // Back-to-back specials and normals with an always-ready sink.
        push(32'h7F80_0000, 32'h3F80_0000, 0, 1'b0);
        push(32'h7FC0_0001, 32'h0000_0000, 0, 1'b0);
        push(32'h3F00_0000, 32'h3F00_0000, 0, 1'b0);
        push(32'hFF80_0000, 32'h3F80_0000, 0, 1'b0);
        idle(40);

        // Backpressure: one result held, FIFO fills, then drain in order.
        res_ready = 1'b0;
        fork
            begin
                push(32'h4000_0000, 32'h4000_0000, 0, 1'b1);
                push(32'h3F80_0000, 32'h3F80_0000, 0, 1'b1);
                push(32'h4040_0000, 32'h3F80_0000, 0, 1'b1);
                push(32'h40A0_0000, 32'h3F80_0000, 0, 1'b1);
                push(32'h4120_0000, 32'h4000_0000, 0, 1'b1);
                push(32'h3F00_0000, 32'h3F00_0000, 0, 1'b1);
            end
            begin
                repeat (30) @(negedge clk);
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_res_valid", 64'(res_valid), 64'(1));
                check("stall_res_sum", 64'(res_sum), 64'(32'h4080_0000));
                check("stall_busy", 64'(busy), 64'(0));
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        idle(60);

        // Asynchronous reset while the op is in S_WAIT.
        push(32'h3F80_0000, 32'h3F80_0000, 7, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_res_valid", 64'(res_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        push(32'h4040_0000, 32'h3F80_0000, 7, 1'b0);
        idle(12);

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
